// File: rtl/operand_fetch_seq_pkg.sv
// Shared constants for the operand fetch sequencer: FSM encodings, operand size, byte lanes.
package operand_fetch_seq_pkg;

  localparam int MAXB = 4;
  localparam int OPW  = 8 * MAXB;

  localparam int          STW       = 2;
  localparam logic [1:0]  OFS_IDLE  = 2'd0;
  localparam logic [1:0]  OFS_FETCH = 2'd1;
  localparam logic [1:0]  OFS_DONE  = 2'd2;

  // Halfword lanes: the even byte sits in the low lane, the odd byte in the high lane.
  localparam int LANE_EVEN_LSB = 0;
  localparam int LANE_ODD_LSB  = 8;

  function automatic logic [2:0] clamp_count(input logic [2:0] n);
    return (n > 3'(MAXB)) ? 3'(MAXB) : n;
  endfunction

endpackage

// File: rtl/operand_fetch_seq_byte_lane_sel.sv
// Picks the operand byte(s) a halfword read contributes, given byte parity and bytes remaining.
module byte_lane_sel
  import operand_fetch_seq_pkg::*;
(
  input  logic [15:0] mem_rdata,
  input  logic        odd,
  input  logic [2:0]  remaining,
  output logic [7:0]  byte0,
  output logic [7:0]  byte1,
  output logic [1:0]  nbytes
);

  always_comb begin
    byte0  = '0;
    byte1  = '0;
    nbytes = 2'd1;
    if (odd) begin
      byte0 = mem_rdata[LANE_ODD_LSB +: 8];
    end else begin
      byte0 = mem_rdata[LANE_EVEN_LSB +: 8];
      byte1 = mem_rdata[LANE_ODD_LSB +: 8];
      if (remaining >= 3'd2) nbytes = 2'd2;
    end
  end

endmodule

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: reads 0-4 big-endian operand bytes over a halfword port.
// Optional build macro OPERAND_SIGN_EXT_EN enables sign extension of 1-3 byte operands.
module operand_fetch_seq
  import operand_fetch_seq_pkg::*;
#(
  parameter int PCW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PCW-1:0]   start_pc,
  input  logic [2:0]       param_count,
  input  logic             sign,
  output logic             busy,
  output logic             mem_req,
  output logic [PCW-2:0]   mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata,
  output logic             param_even,
  output logic [7:0]       parameter_number,
  output logic [OPW-1:0]   operand,
  output logic             operand_valid,
  output logic [PCW-1:0]   next_pc,
  output logic [STW-1:0]   fsm_state
);

  // Handshake: mem_req stays high with a stable mem_addr until the cycle mem_ack is
  // sampled high; that cycle's mem_rdata is consumed and the next address (if any)
  // appears on the following cycle.

  logic [STW-1:0] state;
  logic [PCW-1:0] cur_byte;
  logic [PCW-1:0] end_pc;
  logic [2:0]     remaining;
  logic [2:0]     count_q;
  logic           sign_q;
  logic           pos_valid;
  logic [OPW-1:0] acc;

  logic [7:0]     byte0;
  logic [7:0]     byte1;
  logic [1:0]     nbytes;
  logic [OPW-1:0] acc_next;
  logic [2:0]     rem_next;
  logic [2:0]     eff_count;
  logic [PCW-1:0] start_end;

  byte_lane_sel u_lane (
    .mem_rdata (mem_rdata),
    .odd       (cur_byte[0]),
    .remaining (remaining),
    .byte0     (byte0),
    .byte1     (byte1),
    .nbytes    (nbytes)
  );

  assign eff_count = clamp_count(param_count);
  assign start_end = start_pc + PCW'(eff_count);
  assign rem_next  = remaining - {1'b0, nbytes};
  assign acc_next  = (nbytes == 2'd2) ? {acc[OPW-17:0], byte0, byte1}
                                      : {acc[OPW-9:0], byte0};

  function automatic logic [OPW-1:0] finish_operand(input logic [OPW-1:0] v);
`ifdef OPERAND_SIGN_EXT_EN
    logic [OPW-1:0] r;
    r = v;
    if (sign_q) begin
      case (count_q)
        3'd1:    r = {{24{v[7]}},  v[7:0]};
        3'd2:    r = {{16{v[15]}}, v[15:0]};
        3'd3:    r = {{8{v[23]}},  v[23:0]};
        default: r = v;
      endcase
    end
    return r;
`else
    return v;
`endif
  endfunction

`ifndef OPERAND_SIGN_EXT_EN
  logic unused_sign_cfg;
  assign unused_sign_cfg = ^{sign_q, count_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= OFS_IDLE;
      cur_byte         <= '0;
      end_pc           <= '0;
      remaining        <= '0;
      count_q          <= '0;
      sign_q           <= 1'b0;
      pos_valid        <= 1'b0;
      acc              <= '0;
      parameter_number <= '0;
      operand          <= '0;
      next_pc          <= '0;
    end else begin
      case (state)
        OFS_IDLE: begin
          if (start) begin
            cur_byte         <= start_pc;
            count_q          <= eff_count;
            sign_q           <= sign;
            remaining        <= eff_count;
            pos_valid        <= 1'b1;
            acc              <= '0;
            parameter_number <= '0;
            end_pc           <= start_end;
            if (eff_count == 3'd0) begin
              state   <= OFS_DONE;
              operand <= '0;
              next_pc <= start_end;
            end else begin
              state <= OFS_FETCH;
            end
          end
        end
        OFS_FETCH: begin
          if (mem_ack) begin
            acc              <= acc_next;
            cur_byte         <= cur_byte + PCW'(nbytes);
            remaining        <= rem_next;
            parameter_number <= parameter_number + {6'd0, nbytes};
            if (rem_next == 3'd0) begin
              state   <= OFS_DONE;
              operand <= finish_operand(acc_next);
              next_pc <= end_pc;
            end
          end
        end
        OFS_DONE: state <= OFS_IDLE;
        default:  state <= OFS_IDLE;
      endcase
    end
  end

  // param_even is masked until the first start so every output reads 0 out of reset.
  assign busy          = (state != OFS_IDLE);
  assign mem_req       = (state == OFS_FETCH);
  assign mem_addr      = cur_byte[PCW-1:1];
  assign param_even    = pos_valid & ~cur_byte[0];
  assign operand_valid = (state == OFS_DONE);
  assign fsm_state     = state;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Self-checking bench for operand_fetch_seq: directed plan cases plus randomized runs
// checked against a byte-level reference model.
module tb_operand_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] start_pc;
  logic [2:0]  param_count;
  logic        sign;
  logic        busy;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        param_even;
  logic [7:0]  parameter_number;
  logic [31:0] operand;
  logic        operand_valid;
  logic [15:0] next_pc;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] mem [0:32767];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [14:0] addr_log[$];
  logic        pe_log[$];

  operand_fetch_seq dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .start_pc         (start_pc),
    .param_count      (param_count),
    .sign             (sign),
    .busy             (busy),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .param_even       (param_even),
    .parameter_number (parameter_number),
    .operand          (operand),
    .operand_valid    (operand_valid),
    .next_pc          (next_pc),
    .fsm_state        (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory responder: acks after ack_delay idle request cycles, logs each accepted read
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_cnt  = 0;
        addr_log.push_back(mem_addr);
        pe_log.push_back(param_even);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      wait_cnt  = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // run one fetch sequence and check it against the byte-level model
  task automatic run_txn(input logic [15:0] pc, input logic [2:0] cnt, input logic sgn,
                         input int dly, input string name);
    logic [14:0] exp_q[$];
    logic        pe_exp[$];
    logic [31:0] exp_op;
    logic [15:0] a;
    logic [15:0] hw;
    logic [7:0]  b;
    int          eff;
    int          cycles;
    int          exp_lat;
    eff    = (cnt > 3'd4) ? 4 : int'(cnt);
    exp_op = 32'd0;
    for (int i = 0; i < eff; i++) begin
      a  = pc + 16'(i);
      hw = mem[a[15:1]];
      b  = a[0] ? hw[15:8] : hw[7:0];
      exp_op = (exp_op << 8) | {24'd0, b};
      if (exp_q.size() == 0 || exp_q[$] != a[15:1]) begin
        exp_q.push_back(a[15:1]);
        pe_exp.push_back(~a[0]);
      end
    end
`ifdef OPERAND_SIGN_EXT_EN
    if (sgn && eff >= 1 && eff <= 3 && exp_op[8*eff-1])
      exp_op = exp_op | ~((32'd1 << (8*eff)) - 32'd1);
`endif
    exp_lat = 1 + exp_q.size() * (1 + dly);

    ack_delay = dly;
    addr_log.delete();
    pe_log.delete();
    start_pc    = pc;
    param_count = cnt;
    sign        = sgn;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    start_pc    = 16'($urandom);
    cycles      = 1;
    while (!operand_valid && cycles < 200) begin
      tick();
      cycles++;
    end

    n_cmp++;
    if (!operand_valid) begin
      n_fail++;
      $display("FAIL %s timeout: no operand_valid within %0d cycles", name, cycles);
      return;
    end
    n_cmp++;
    if (cycles !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_lat);
    end
    n_cmp++;
    if (operand !== exp_op) begin
      n_fail++;
      $display("FAIL %s operand: got %h want %h", name, operand, exp_op);
    end
    n_cmp++;
    if (next_pc !== pc + 16'(eff)) begin
      n_fail++;
      $display("FAIL %s next_pc: got %h want %h", name, next_pc, pc + 16'(eff));
    end
    n_cmp++;
    if (parameter_number !== 8'(eff)) begin
      n_fail++;
      $display("FAIL %s parameter_number: got %0d want %0d", name, parameter_number, eff);
    end
    n_cmp++;
    if (addr_log != exp_q) begin
      n_fail++;
      $display("FAIL %s addresses: got %p want %p", name, addr_log, exp_q);
    end
    n_cmp++;
    if (pe_log != pe_exp) begin
      n_fail++;
      $display("FAIL %s param_even: got %p want %p", name, pe_log, pe_exp);
    end
    tick();
    n_cmp++;
    if (operand_valid !== 1'b0 || busy !== 1'b0 || operand !== exp_op) begin
      n_fail++;
      $display("FAIL %s after_done: valid=%b busy=%b operand=%h want 0/0/%h",
               name, operand_valid, busy, operand, exp_op);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_pc = 16'h0;
    param_count = 3'd0;
    sign = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, mem_req, mem_addr, param_even, parameter_number, operand, operand_valid,
         next_pc, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b req=%b addr=%h pe=%b pn=%0d op=%h v=%b npc=%h st=%0d want all 0",
               busy, mem_req, mem_addr, param_even, parameter_number, operand, operand_valid,
               next_pc, fsm_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    mem[15'h10] = 16'h2211;
    mem[15'h11] = 16'h4433;
    run_txn(16'h0020, 3'd4, 1'b0, 0, "aligned4");
    mem[15'h08] = 16'h3400;
    mem[15'h09] = 16'h0056;
    run_txn(16'h0011, 3'd2, 1'b0, 0, "odd2");
    run_txn(16'h0100, 3'd0, 1'b0, 0, "count0");
    mem[15'h18] = 16'h0080;
    run_txn(16'h0030, 3'd1, 1'b1, 0, "sign1");
    run_txn(16'h0030, 3'd1, 1'b0, 0, "unsigned1");
    mem[15'h7FFF] = 16'($urandom);
    mem[15'h0000] = 16'($urandom);
    run_txn(16'hFFFF, 3'd3, 1'b0, 0, "wrap3");
    run_txn(16'h0020, 3'd4, 1'b0, 3, "delay3");
    run_txn(16'h0011, 3'd7, 1'b0, 1, "clamp7");
  endtask

  task automatic test_busy_and_reset();
    int vcount;
    ack_delay   = 50;
    start_pc    = 16'h0200;
    param_count = 3'd4;
    sign        = 1'b0;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start_pc    = 16'h0400;
        param_count = 3'd0;
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 15'h0100 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_req cycle %0d: req=%b addr=%h busy=%b want 1/0100/1",
                 i, mem_req, mem_addr, busy);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    tick();
    n_cmp++;
    if ({busy, mem_req, mem_addr, param_even, parameter_number, operand, operand_valid,
         next_pc, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: busy=%b req=%b addr=%h pe=%b pn=%0d v=%b st=%0d want all 0",
               busy, mem_req, mem_addr, param_even, parameter_number, operand_valid, fsm_state);
    end
    rst       = 1'b0;
    ack_delay = 0;
    vcount    = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (operand_valid || mem_req) vcount++;
    end
    n_cmp++;
    if (vcount !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d active cycles want 0", vcount);
    end
  endtask

  task automatic test_random();
    logic [15:0] pc;
    for (int i = 0; i < 40; i++) begin
      pc = 16'($urandom);
      for (int k = 0; k < 6; k++) mem[15'(pc[15:1] + 15'(k))] = 16'($urandom);
      run_txn(pc, 3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    test_reset();
    test_directed();
    test_busy_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_seq.md
Name: operand_fetch_seq

Overview:
- Sequences fetching of a bytecode instruction's operand bytes (0-4 bytes, big-endian) from the 16-bit-wide bytecode memory.
- Sits between the decode state machine and the bytecode memory port.
- Tracks byte parity (param_even) and operand byte index (parameter_number), issues halfword reads, and assembles the operand word.
- Decode starts it with a PC and byte count, then receives one operand_valid pulse.

Parameters:
- PCW, 16, byte-address width of PC.
- MAXB, 4, maximum operand bytes per instruction (fixed 4; operand width = 8*MAXB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin sequence; sampled only in IDLE.
- start_pc  in  PCW  byte address of first operand byte.
- param_count  in  3  operand byte count, 0..4; values 5..7 treated as 4.
- sign  in  1  operand is signed (used only with OPERAND_SIGN_EXT_EN).
- busy  out  1  high in any state other than IDLE.
- mem_req  out  1  halfword read request.
- mem_addr  out  PCW-1  halfword address = byte address >> 1.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  16  [7:0] = even byte, [15:8] = odd byte.
- param_even  out  1  current byte address is even.
- parameter_number  out  8  index of the next operand byte to capture (0-based).
- operand  out  32  assembled operand, right-aligned, first byte most significant.
- operand_valid  out  1  one-cycle pulse; operand and next_pc valid.
- next_pc  out  PCW  start_pc + param_count.

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on rst.
- Reset values: all outputs 0, state IDLE. rst mid-sequence aborts immediately: mem_req drops the same edge and any pending mem_ack is ignored.
- States (encodings in me_consts.vh):
  - IDLE: busy=0. start=1 latches start_pc, param_count and sign; clears the accumulator and parameter_number. Next state is DONE if count==0, else FETCH.
  - FETCH: mem_req=1, held until mem_ack; mem_addr = cur_byte>>1.
    - On mem_ack, if cur_byte is odd: capture [15:8] (1 byte).
    - If cur_byte is even: capture [7:0]; if remaining is still >0, also capture [15:8] the same cycle.
    - Each captured byte: acc = (acc<<8)|byte; cur_byte++; remaining--; parameter_number++.
    - Stay in FETCH if remaining>0 (new address next cycle); otherwise go to DONE.
  - DONE: operand_valid=1 for exactly one cycle; operand=acc; next_pc=start_pc+count (mod 2^PCW). Return to IDLE.
- param_even = ~cur_byte[0], continuously.
- start while busy is ignored. No queuing.
- Latency: start to operand_valid is 1 + N_txn + sum of ack wait cycles, with N_txn = number of halfwords touched.
  - Count 0: operand_valid the 2nd cycle after start.
- operand holds its value until the next DONE.
- PC wrap: cur_byte wraps modulo 2^PCW. A halfword address 0x7FFF followed by 0x0000 is legal.
- mem_ack outside FETCH is ignored.

Optional Feature:
- Macro OPERAND_SIGN_EXT_EN.
- Defined: in DONE, if sign=1 and count in 1..3, operand is sign-extended from bit 8*count-1.
- Undefined: operand is always zero-extended and the sign input is unused.

Decomposition:
- Shared include me_consts.vh holds:
  - state width/encodings (OFS_IDLE, OFS_FETCH, OFS_DONE);
  - MAXB;
  - the halfword byte-lane constants.
- One sub-module, byte_lane_sel: combinational.
  - Inputs: mem_rdata, cur_byte[0], remaining.
  - Outputs: byte0, byte1, nbytes (1 or 2).

Test Plan:
- start_pc=0x0020, count=4, hw0x10=0x2211, hw0x11=0x4433, ack immediate -> 2 transactions, operand=0x11223344, next_pc=0x0024, single operand_valid pulse.
- start_pc=0x0011, count=2, hw0x08=0x3400, hw0x09=0x0056 -> addresses 0x08 then 0x09, operand=0x00003456; param_even reads 0 then 1.
- count=0, start_pc=0x0100 -> no mem_req; operand_valid 2nd cycle after start, operand=0, next_pc=0x0100.
- count=1, byte 0x80, sign=1 -> 0xFFFFFF80 with OPERAND_SIGN_EXT_EN, 0x00000080 without.
- mem_ack delayed 3 cycles; start pulsed while busy; rst asserted mid-FETCH -> mem_req held steady, second start ignored, and after rst: all outputs 0, IDLE, no operand_valid.
- start_pc=0xFFFF, count=3 -> addresses 0x7FFF, 0x0000, 0x0000 not re-read (2 transactions), next_pc=0x0002.
